// File: rtl/spi_master_multi.sv
// ============================================================================
// spi_master_multi : register-mapped SPI master with runtime CPOL/CPHA, SCK
// divider, one-hot chip selects and rx-valid/overrun flags.  Rev 1.0
// ============================================================================
`default_nettype none

module spi_master_multi #(
  parameter int CS_COUNT   = 1,
  parameter int DIV_RESET  = 0,
  parameter int CPOL_RESET = 1,
  parameter int CPHA_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                avalid,
  input  logic                awe,
  input  logic [7:0]          adata,
  input  logic [1:0]          aaddr,
  output logic                bvalid,
  output logic [7:0]          bdata,
  output logic [CS_COUNT-1:0] spi_cs,
  output logic                spi_clk,
  output logic                spi_mosi,
  input  logic                spi_miso
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cs_idx_q, cs_idx_d;
  logic        cs_assert_q, cs_assert_d;
  logic        cpol_q, cpol_d;
  logic        cpha_q, cpha_d;
  logic [7:0]  div_q, div_d;
  logic        rx_valid_q, rx_valid_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [4:0]  ecnt_q, ecnt_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        bvalid_q, bvalid_d;
  logic [7:0]  bdata_q, bdata_d;

  logic w_busy;
  logic w_wr;
  logic w_rd;

  assign w_busy = (state_q == S_XFER);
  assign w_wr   = avalid & awe;
  assign w_rd   = avalid & ~awe;

  always_comb begin
    state_d     = state_q;
    cs_idx_d    = cs_idx_q;
    cs_assert_d = cs_assert_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    div_d       = div_q;
    rx_valid_d  = rx_valid_q;
    ovr_d       = ovr_q;
    tx_d        = tx_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    hcnt_d      = hcnt_q;
    ecnt_d      = ecnt_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    bvalid_d    = avalid;
    bdata_d     = bdata_q;

    if (w_rd) begin
      case (aaddr)
        2'd0: bdata_d = {w_busy, rx_valid_q, cpha_q, cpol_q, cs_assert_q, cs_idx_q};
        2'd1: begin
          bdata_d    = rx_data_q;
          rx_valid_d = 1'b0;
        end
        2'd2: bdata_d = div_q;
        default: begin
          bdata_d = {7'd0, ovr_q};
          ovr_d   = 1'b0;
        end
      endcase
    end

    if (w_wr) begin
      case (aaddr)
        2'd0: if (!w_busy) begin
          cs_idx_d    = adata[2:0];
          cs_assert_d = adata[3];
          cpol_d      = adata[4];
          cpha_d      = adata[5];
        end
        2'd1: if (w_busy) begin
          ovr_d = 1'b1;
        end else begin
          state_d = S_XFER;
          hcnt_d  = 8'd0;
          ecnt_d  = 5'd0;
          // cpha=0 presents the MSB before the first edge; cpha=1 drives it on edge 1
          if (!cpha_q) begin
            mosi_d = adata[7];
            tx_d   = {adata[6:0], 1'b0};
          end else begin
            tx_d   = adata;
          end
        end
        2'd2: if (!w_busy) div_d = adata;
        default: ;
      endcase
    end

    if (state_q == S_IDLE) begin
      sclk_d = cpol_d;
    end else if (hcnt_q == div_q) begin
      hcnt_d = 8'd0;
      ecnt_d = ecnt_q + 5'd1;
      sclk_d = ~sclk_q;
      if (!ecnt_q[0]) begin
        if (!cpha_q) begin
          rx_sh_d = {rx_sh_q[6:0], spi_miso};
        end else begin
          mosi_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end else begin
        if (cpha_q) begin
          rx_sh_d = {rx_sh_q[6:0], spi_miso};
        end else if (ecnt_q != 5'd15) begin
          mosi_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
      // Edge 16 ends the transfer; rx_valid set overrides a same-cycle DATA read clear
      if (ecnt_q == 5'd15) begin
        state_d    = S_IDLE;
        sclk_d     = cpol_q;
        ecnt_d     = 5'd0;
        rx_data_d  = rx_sh_d;
        rx_valid_d = 1'b1;
      end
    end else begin
      hcnt_d = hcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cs_idx_q    <= 3'd0;
      cs_assert_q <= 1'b0;
      cpol_q      <= 1'(CPOL_RESET);
      cpha_q      <= 1'(CPHA_RESET);
      div_q       <= 8'(DIV_RESET);
      rx_valid_q  <= 1'b0;
      ovr_q       <= 1'b0;
      tx_q        <= 8'd0;
      rx_sh_q     <= 8'd0;
      rx_data_q   <= 8'd0;
      hcnt_q      <= 8'd0;
      ecnt_q      <= 5'd0;
      sclk_q      <= 1'(CPOL_RESET);
      mosi_q      <= 1'b1;
      bvalid_q    <= 1'b0;
      bdata_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      cs_idx_q    <= cs_idx_d;
      cs_assert_q <= cs_assert_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      div_q       <= div_d;
      rx_valid_q  <= rx_valid_d;
      ovr_q       <= ovr_d;
      tx_q        <= tx_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      hcnt_q      <= hcnt_d;
      ecnt_q      <= ecnt_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      bvalid_q    <= bvalid_d;
      bdata_q     <= bdata_d;
    end
  end

  for (genvar i = 0; i < CS_COUNT; i++) begin : g_cs
    assign spi_cs[i] = ~(cs_assert_q && (cs_idx_q == 3'(i)));
  end

  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;
  assign bvalid   = bvalid_q;
  assign bdata    = bdata_q;

endmodule

`default_nettype wire
